// File: rtl/cmp_share_arbiter.sv
// Round-robin shared 64-bit set-less-than unit: IDLE accepts one request, CMP evaluates, RESP holds the result.
// Optional per-requester grant counters are compiled in with `define CMP_ARB_STATS_EN.
module cmp_share_arbiter #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 2,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_signed,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_result
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]      stat_grants
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t           state;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    cand;
  logic             found;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_s;
  logic [IDW-1:0]   id_q;
  logic             res_q;
  logic             rsp_valid_q;
  logic             lt;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]     = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi]     = req_b[gi*WIDTH +: WIDTH];
      assign req_ready[gi] = accept && (grant_idx == IW'(gi));
    end
  endgenerate

  // Search starts one past the last winner so every waiting requester gets a turn.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept = found && (state == IDLE) && rst_n;

  // Differing signs decide directly; same signs reduce to an unsigned compare of the low bits.
  always_comb begin
    if (op_s && (op_a[WIDTH-1] != op_b[WIDTH-1]))
      lt = op_a[WIDTH-1];
    else if (op_s)
      lt = op_a[WIDTH-2:0] < op_b[WIDTH-2:0];
    else
      lt = op_a < op_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= IW'(NREQ - 1);
      op_a        <= '0;
      op_b        <= '0;
      op_s        <= 1'b0;
      id_q        <= '0;
      res_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= a_arr[grant_idx];
            op_b       <= b_arr[grant_idx];
            op_s       <= req_signed[grant_idx];
            id_q       <= IDW'(grant_idx);
            last_grant <= grant_idx;
            state      <= CMP;
          end
        end
        CMP: begin
          res_q       <= lt;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = {{(WIDTH-1){1'b0}}, res_q};

`ifdef CMP_ARB_STATS_EN
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stats
      logic [15:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt <= '0;
        else if (accept && (grant_idx == IW'(gi)) && (cnt != 16'hFFFF))
          cnt <= cnt + 16'd1;
      end
      assign stat_grants[gi*16 +: 16] = cnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: compare values, fairness, backpressure, reset abort
// and (with CMP_ARB_STATS_EN) grant counters.
module tb_cmp_share_arbiter;

  localparam int W   = 64;
  localparam int N   = 2;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_signed;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_result;
`ifdef CMP_ARB_STATS_EN
  logic [N*16-1:0]  stat_grants;
`endif

  int n_vec = 0;
  int n_err = 0;

  cmp_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
`ifdef CMP_ARB_STATS_EN
    ,
    .stat_grants(stat_grants)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion within 500000 time units");
    $fatal(1, "timeout");
  end

  task automatic test_reset;
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 64'd0) begin
      n_err++;
      $display("FAIL reset_state: req_ready=%b rsp_valid=%b rsp_id=%0d rsp_result=%h, required all zero",
               req_ready, rsp_valid, rsp_id, rsp_result);
    end
    $display("reset: req_ready=%b rsp_valid=%b rsp_id=%0d", req_ready, rsp_valid, rsp_id);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_values;
    logic [W-1:0] va   [10];
    logic [W-1:0] vb   [10];
    logic         vs   [10];
    logic [W-1:0] vexp [10];
    va[0] = 64'd5;                    vb[0] = 64'd10;                   vs[0] = 1'b1; vexp[0] = 64'd1;
    va[1] = 64'd10;                   vb[1] = 64'd5;                    vs[1] = 1'b1; vexp[1] = 64'd0;
    va[2] = 64'd7;                    vb[2] = 64'd7;                    vs[2] = 1'b1; vexp[2] = 64'd0;
    va[3] = 64'hFFFF_FFFF_FFFF_FFFF;  vb[3] = 64'd1;                    vs[3] = 1'b1; vexp[3] = 64'd1;
    va[4] = 64'hFFFF_FFFF_FFFF_FFF6;  vb[4] = 64'hFFFF_FFFF_FFFF_FFFB;  vs[4] = 1'b1; vexp[4] = 64'd1;
    va[5] = 64'h7FFF_FFFF_FFFF_FFFF;  vb[5] = 64'h8000_0000_0000_0000;  vs[5] = 1'b1; vexp[5] = 64'd0;
    va[6] = 64'h8000_0000_0000_0000;  vb[6] = 64'h7FFF_FFFF_FFFF_FFFF;  vs[6] = 1'b1; vexp[6] = 64'd1;
    va[7] = 64'h7FFF_FFFF_FFFF_FFFF;  vb[7] = 64'hFFFF_FFFF_FFFF_FFFF;  vs[7] = 1'b1; vexp[7] = 64'd0;
    va[8] = 64'h8000_0000_0000_0000;  vb[8] = 64'd1;                    vs[8] = 1'b1; vexp[8] = 64'd1;
    va[9] = 64'd1;                    vb[9] = 64'hFFFF_FFFF_FFFF_FFFF;  vs[9] = 1'b0; vexp[9] = 64'd1;
    for (int i = 0; i < 10; i++) begin
      req_valid        = 2'b01;
      req_a[W-1:0]     = va[i];
      req_b[W-1:0]     = vb[i];
      req_signed[0]    = vs[i];
      rsp_ready        = 1'b1;
      #1;
      n_vec++;
      if (req_ready !== 2'b01) begin
        n_err++;
        $display("FAIL value%0d_grant: req_ready=%b required 01", i, req_ready);
      end
      @(negedge clk);
      req_valid    = 2'b00;
      req_a[W-1:0] = ~va[i];
      req_b[W-1:0] = ~vb[i];
      n_vec++;
      if (rsp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL value%0d_latency: rsp_valid=%b one cycle after accept, required 0", i, rsp_valid);
      end
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== vexp[i]) begin
        n_err++;
        $display("FAIL value%0d_result: valid=%b id=%0d result=%h, required valid=1 id=0 result=%h",
                 i, rsp_valid, rsp_id, rsp_result, vexp[i]);
      end
      $display("value%0d: a=%h b=%h signed=%b -> result=%h", i, va[i], vb[i], vs[i], rsp_result);
      @(negedge clk);
    end
  endtask

  task automatic test_fairness;
    int exp_id;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    req_valid  = 2'b11;
    req_a      = {64'd2, 64'd1};
    req_b      = {64'd1, 64'd2};
    req_signed = 2'b11;
    rsp_ready  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_id = t % 2;
      #1;
      n_vec++;
      if (req_ready !== (2'b01 << exp_id)) begin
        n_err++;
        $display("FAIL fair%0d_grant: req_ready=%b required %b", t, req_ready, 2'b01 << exp_id);
      end
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
        n_err++;
        $display("FAIL fair%0d_cmp: rsp_valid=%b req_ready=%b, required 0 and 00", t, rsp_valid, req_ready);
      end
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_id) || rsp_result !== ((exp_id == 0) ? 64'd1 : 64'd0)) begin
        n_err++;
        $display("FAIL fair%0d_rsp: valid=%b id=%0d result=%h, required valid=1 id=%0d result=%0d",
                 t, rsp_valid, rsp_id, rsp_result, exp_id, (exp_id == 0) ? 1 : 0);
      end
      $display("fair%0d: grant id=%0d result=%h", t, rsp_id, rsp_result);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    req_valid        = 2'b10;
    req_a[2*W-1:W]   = 64'd3;
    req_b[2*W-1:W]   = 64'd9;
    req_signed       = 2'b00;
    rsp_ready        = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 2'b10) begin
      n_err++;
      $display("FAIL bp_grant: req_ready=%b required 10", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b01;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 64'd1 || req_ready !== 2'b00) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b id=%0d result=%h req_ready=%b, required 1 1 1 00",
                 k, rsp_valid, rsp_id, rsp_result, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: rsp_valid=%b required 1", rsp_valid);
    end
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL bp_done: rsp_valid=%b req_ready=%b, required 0 and 01", rsp_valid, req_ready);
    end
    $display("backpressure: held id=1 result=1 for 5 cycles, then completed");
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      n_err++;
      $display("FAIL bp_idle: rsp_valid=%b req_ready=%b, required 0 and 00", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    req_valid      = 2'b10;
    req_a[2*W-1:W] = 64'd5;
    req_b[2*W-1:W] = 64'd5;
    req_signed     = 2'b11;
    rsp_ready      = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 2'b10) begin
      n_err++;
      $display("FAIL midrst_grant: req_ready=%b required 10", req_ready);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 64'd0) begin
      n_err++;
      $display("FAIL midrst_outputs: req_ready=%b valid=%b id=%0d result=%h, required all zero",
               req_ready, rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    req_valid    = 2'b11;
    req_a[W-1:0] = 64'hFFFF_FFFF_FFFF_FFFE;
    req_b[W-1:0] = 64'd0;
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL midrst_first: req_ready=%b required 01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 64'd1) begin
      n_err++;
      $display("FAIL midrst_rsp: valid=%b id=%0d result=%h, required valid=1 id=0 result=1",
               rsp_valid, rsp_id, rsp_result);
    end
    $display("reset_mid: aborted id=1, first after reset id=%0d result=%h", rsp_id, rsp_result);
    @(negedge clk);
  endtask

`ifdef CMP_ARB_STATS_EN
  task automatic test_stats;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    repeat (9) @(negedge clk);
    req_valid = 2'b00;
    n_vec++;
    if (stat_grants !== {16'd3, 16'd0}) begin
      n_err++;
      $display("FAIL stats: stat_grants=%h required 00030000", stat_grants);
    end
    $display("stats: stat_grants=%h", stat_grants);
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_values();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef CMP_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
